// File: rtl/hard_clk_req_or_n_if.sv
// Request/enable bundle between the clock-request merger and its requesters.
interface hard_clk_req_or_n_if #(
  parameter int NB_CH = 4
);
  logic [NB_CH-1:0] i_req;
  logic [NB_CH-1:0] i_mask;
  logic             i_force_on;
  logic             o_clk_en;
  logic [NB_CH-1:0] o_ack;
  logic [1:0]       o_state;

  modport master (
    output i_req, i_mask, i_force_on,
    input  o_clk_en, o_ack, o_state
  );

  modport slave (
    input  i_req, i_mask, i_force_on,
    output o_clk_en, o_ack, o_state
  );
endinterface

// File: rtl/hard_clk_req_or_n.sv
// Merges NB_CH clock requests into one registered clock-enable with a
// turn-off hold-off, plus per-channel acknowledges.
module hard_clk_req_or_n #(
  parameter int NB_CH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  hard_clk_req_or_n_if.slave bus
);

  localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StOn   = 2'd1,
    StHold = 2'd2
  } state_e;

  state_e           r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_clk_en;
  logic [NB_CH-1:0] r_ack;
  logic [NB_CH-1:0] w_req_s;
  logic             w_any_req;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_req_s = bus.i_req;
  end else begin : g_sync
    logic [NB_CH-1:0] r_sync [SYNC_STAGES];

    // Per-bit synchroniser chain for the asynchronous requests.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      end else begin
        r_sync[0] <= bus.i_req;
        for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
    end

    assign w_req_s = r_sync[SYNC_STAGES-1];
  end

  // Mask is i_clk-domain and applied after the synchroniser, so it acts in one cycle.
  assign w_any_req = (|(w_req_s & ~bus.i_mask)) | bus.i_force_on;

  // Next-state and hold counter; a new request in HOLD wins over expiry.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StOff: begin
        if (w_any_req) w_state_d = StOn;
      end
      StOn: begin
        if (!w_any_req) begin
          if (HOLD_CYCLES > 0) begin
            w_state_d = StHold;
            w_cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          end else begin
            w_state_d = StOff;
          end
        end
      end
      StHold: begin
        if (w_any_req) begin
          w_state_d = StOn;
          w_cnt_d   = '0;
        end else if (r_cnt == '0) begin
          w_state_d = StOff;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_d = StOff;
        w_cnt_d   = '0;
      end
    endcase
  end

  // State, counter and outputs; enable is registered from next-state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= StOff;
      r_cnt    <= '0;
      r_clk_en <= 1'b0;
      r_ack    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_clk_en <= (w_state_d != StOff);
      // Ack uses the current enable so it trails the enable by one cycle.
      r_ack    <= {NB_CH{r_clk_en}} & w_req_s & ~bus.i_mask;
    end
  end

  assign bus.o_clk_en = r_clk_en;
  assign bus.o_ack    = r_ack;
  assign bus.o_state  = r_state;

endmodule

// File: tb/tb_hard_clk_req_or_n.sv
// Scoreboard bench: stimulus pushes cycle-tagged expectations, a negedge
// monitor pops and compares whatever falls due in that cycle.
module tb_hard_clk_req_or_n;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_c;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hard_clk_req_or_n_if #(.NB_CH(4)) if_a ();
  hard_clk_req_or_n_if #(.NB_CH(4)) if_b ();
  hard_clk_req_or_n_if #(.NB_CH(8)) if_c ();

  hard_clk_req_or_n #(.NB_CH(4), .SYNC_STAGES(2), .HOLD_CYCLES(8)) dut_a (
    .i_clk  (clk),
    .i_rst_n(rst_a),
    .bus    (if_a)
  );

  hard_clk_req_or_n #(.NB_CH(4), .SYNC_STAGES(2), .HOLD_CYCLES(0)) dut_b (
    .i_clk  (clk),
    .i_rst_n(rst_a),
    .bus    (if_b)
  );

  hard_clk_req_or_n #(.NB_CH(8), .SYNC_STAGES(0), .HOLD_CYCLES(8)) dut_c (
    .i_clk  (clk),
    .i_rst_n(rst_c),
    .bus    (if_c)
  );

  // sel: 0..2 = A clk_en/ack/state, 3..5 = B, 6..8 = C
  typedef struct {
    int         c;
    int         s;
    logic [7:0] v;
    string      nm;
  } exp_t;

  exp_t sb[$];

  task automatic expect_at(input int c, input int s, input logic [7:0] v, input string nm);
    exp_t e;
    e.c  = c;
    e.s  = s;
    e.v  = v;
    e.nm = nm;
    sb.push_back(e);
  endtask

  function automatic logic [7:0] actual(input int s);
    case (s)
      0:       return {7'd0, if_a.o_clk_en};
      1:       return {4'd0, if_a.o_ack};
      2:       return {6'd0, if_a.o_state};
      3:       return {7'd0, if_b.o_clk_en};
      4:       return {4'd0, if_b.o_ack};
      5:       return {6'd0, if_b.o_state};
      6:       return {7'd0, if_c.o_clk_en};
      7:       return if_c.o_ack;
      8:       return {6'd0, if_c.o_state};
      default: return 8'hxx;
    endcase
  endfunction

  // Monitor: compare every expectation that falls due this cycle.
  always @(negedge clk) begin
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].c == cyc) begin
        act = actual(sb[i].s);
        total++;
        if (act !== sb[i].v) begin
          bad++;
          $display("FAIL %s @cyc %0d: got %h want %h", sb[i].nm, cyc, act, sb[i].v);
        end
        sb.delete(i);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv_ab(input logic [3:0] req, input logic [3:0] mask, input logic frc);
    if_a.i_req      = req;
    if_a.i_mask     = mask;
    if_a.i_force_on = frc;
    if_b.i_req      = req;
    if_b.i_mask     = mask;
    if_b.i_force_on = frc;
  endtask

  initial begin
    rst_a = 1'b0;
    rst_c = 1'b0;
    drv_ab(4'b0000, 4'b0000, 1'b0);
    if_c.i_req      = '0;
    if_c.i_mask     = '0;
    if_c.i_force_on = 1'b0;

    // Reset state
    for (int c = 1; c <= 2; c++) begin
      expect_at(c, 0, 8'h00, "rst_a_clk_en");
      expect_at(c, 1, 8'h00, "rst_a_ack");
      expect_at(c, 2, 8'h00, "rst_a_state");
      expect_at(c, 3, 8'h00, "rst_b_clk_en");
      expect_at(c, 6, 8'h00, "rst_c_clk_en");
      expect_at(c, 7, 8'h00, "rst_c_ack");
    end
    goto(3);
    rst_a = 1'b1;
    rst_c = 1'b1;

    // Request latency: raise req[2] at 5 -> enable at 8, ack at 9
    expect_at(7, 0, 8'h00, "lat_clk_en_early");
    expect_at(8, 0, 8'h01, "lat_clk_en");
    expect_at(8, 1, 8'h00, "lat_ack_early");
    expect_at(8, 2, 8'h01, "lat_state_on");
    expect_at(9, 1, 8'h04, "lat_ack");
    expect_at(7, 3, 8'h00, "lat_b_clk_en_early");
    expect_at(8, 3, 8'h01, "lat_b_clk_en");
    expect_at(9, 4, 8'h04, "lat_b_ack");
    goto(5);
    drv_ab(4'b0100, 4'b0000, 1'b0);

    // Hold-off: drop at 25 -> ack 0 and HOLD at 28, enable falls at 36
    expect_at(27, 1, 8'h04, "hold_ack_before");
    expect_at(28, 1, 8'h00, "hold_ack_drop");
    expect_at(28, 2, 8'h02, "hold_state");
    for (int c = 28; c <= 35; c++) expect_at(c, 0, 8'h01, "hold_clk_en_on");
    expect_at(36, 0, 8'h00, "hold_clk_en_off");
    expect_at(36, 2, 8'h00, "hold_state_off");
    expect_at(27, 3, 8'h01, "hold0_clk_en_before");
    expect_at(28, 3, 8'h00, "hold0_clk_en_off");
    expect_at(28, 5, 8'h00, "hold0_state_off");
    goto(25);
    drv_ab(4'b0000, 4'b0000, 1'b0);

    // Re-request in HOLD, request on counter==0 cycle, drop/rise same cycle
    for (int c = 43; c <= 100; c++) expect_at(c, 0, 8'h01, "rereq_clk_en_on");
    expect_at(53, 2, 8'h02, "rereq_state_hold");
    expect_at(56, 2, 8'h02, "rereq_state_hold_late");
    expect_at(57, 2, 8'h01, "rereq_state_on");
    expect_at(56, 1, 8'h00, "rereq_ack_early");
    expect_at(58, 1, 8'h02, "rereq_ack1");
    expect_at(53, 3, 8'h00, "rereq_b_off");
    expect_at(57, 3, 8'h01, "rereq_b_on");
    expect_at(63, 2, 8'h02, "cnt0_state_hold");
    expect_at(70, 2, 8'h02, "cnt0_state_last");
    expect_at(71, 2, 8'h01, "cnt0_state_on");
    expect_at(72, 1, 8'h08, "cnt0_ack3");
    for (int c = 81; c <= 86; c++) expect_at(c, 2, 8'h01, "swap_state_on");
    expect_at(82, 1, 8'h08, "swap_ack_old");
    expect_at(83, 1, 8'h04, "swap_ack_new");
    expect_at(101, 0, 8'h00, "swap_drain_off");
    expect_at(101, 2, 8'h00, "swap_drain_state");
    goto(40);
    drv_ab(4'b0001, 4'b0000, 1'b0);
    goto(50);
    drv_ab(4'b0000, 4'b0000, 1'b0);
    goto(54);
    drv_ab(4'b0010, 4'b0000, 1'b0);
    goto(60);
    drv_ab(4'b0000, 4'b0000, 1'b0);
    goto(68);
    drv_ab(4'b1000, 4'b0000, 1'b0);
    goto(80);
    drv_ab(4'b0100, 4'b0000, 1'b0);
    goto(90);
    drv_ab(4'b0000, 4'b0000, 1'b0);

    // Masking
    for (int c = 106; c <= 112; c++) expect_at(c, 0, 8'h00, "mask_clk_en_off");
    expect_at(112, 2, 8'h00, "mask_state_off");
    expect_at(113, 0, 8'h01, "unmask_clk_en");
    expect_at(114, 1, 8'h04, "unmask_ack");
    expect_at(120, 1, 8'h04, "remask_ack_before");
    expect_at(121, 1, 8'h00, "remask_ack_drop");
    expect_at(121, 2, 8'h02, "remask_state_hold");
    expect_at(128, 0, 8'h01, "remask_clk_en_last");
    expect_at(129, 0, 8'h00, "remask_clk_en_off");
    expect_at(129, 2, 8'h00, "remask_state_off");
    goto(105);
    drv_ab(4'b0100, 4'b0100, 1'b0);
    goto(112);
    drv_ab(4'b0100, 4'b0000, 1'b0);
    goto(120);
    drv_ab(4'b0100, 4'b0100, 1'b0);
    goto(130);
    drv_ab(4'b0000, 4'b0000, 1'b0);

    // Force-on
    expect_at(136, 0, 8'h01, "force_clk_en");
    expect_at(136, 2, 8'h01, "force_state_on");
    expect_at(137, 1, 8'h00, "force_ack");
    expect_at(140, 1, 8'h00, "force_ack_mid");
    expect_at(136, 3, 8'h01, "force_b_clk_en");
    expect_at(140, 4, 8'h00, "force_b_ack");
    expect_at(146, 2, 8'h02, "force_rel_hold");
    expect_at(153, 0, 8'h01, "force_rel_last");
    expect_at(154, 0, 8'h00, "force_rel_off");
    expect_at(154, 2, 8'h00, "force_rel_state");
    expect_at(146, 3, 8'h00, "force_b_rel_off");
    goto(135);
    drv_ab(4'b0000, 4'b0000, 1'b1);
    goto(145);
    drv_ab(4'b0000, 4'b0000, 1'b0);

    // Async reset mid-ON on the 8-channel, unsynchronised instance
    expect_at(161, 6, 8'h01, "c_clk_en");
    expect_at(161, 8, 8'h01, "c_state_on");
    expect_at(162, 7, 8'ha5, "c_ack");
    expect_at(164, 7, 8'ha5, "c_ack_hold");
    expect_at(165, 6, 8'h00, "c_arst_clk_en");
    expect_at(165, 7, 8'h00, "c_arst_ack");
    expect_at(165, 8, 8'h00, "c_arst_state");
    expect_at(170, 6, 8'h00, "c_rel_clk_en_early");
    expect_at(171, 6, 8'h01, "c_rel_clk_en");
    expect_at(172, 7, 8'ha5, "c_rel_ack");
    goto(160);
    if_c.i_req = 8'ha5;
    goto(165);
    rst_c = 1'b0;
    #1;
    total++;
    if (if_c.o_clk_en !== 1'b0) begin
      bad++;
      $display("FAIL c_arst_now_clk_en: got %b want 0", if_c.o_clk_en);
    end
    total++;
    if (if_c.o_ack !== 8'h00) begin
      bad++;
      $display("FAIL c_arst_now_ack: got %h want 00", if_c.o_ack);
    end
    total++;
    if (if_c.o_state !== 2'd0) begin
      bad++;
      $display("FAIL c_arst_now_state: got %0d want 0", if_c.o_state);
    end
    goto(170);
    rst_c = 1'b1;

    goto(175);
    foreach (sb[i]) begin
      total++;
      bad++;
      $display("FAIL %s never reached: got none want %h", sb[i].nm, sb[i].v);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hard_clk_req_or_n.md
Name: hard_clk_req_or_n

Overview:
- Parametrised successor of the fixed 4-input hard clock OR cell.
- Merges NB_CH clock-request lines into one registered clock-enable for a downstream clock gate.
- Each request gets an optional synchroniser and a mask bit. Each channel also gets an acknowledge.
- A turn-off hold-off counter stops the enable from chattering when requests toggle.
- Sits in lib_dependent_ips, in front of the hard clock-gate cell of a shared clock branch.

Parameters:
- NB_CH, 4, number of request channels (1..32).
- SYNC_STAGES, 2, flops per request synchroniser (0..3). 0 means the requests are already i_clk-synchronous.
- HOLD_CYCLES, 8, cycles o_clk_en stays high after the last active request drops (0..255).

Ports:
- i_clk  input  1  block clock, free-running.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req  input  NB_CH  per-channel clock request. Asynchronous to i_clk when SYNC_STAGES>0.
- i_mask  input  NB_CH  1 = channel ignored. Quasi-static, i_clk domain.
- i_force_on  input  1  i_clk-domain override that holds the enable on.
- o_clk_en  output  1  registered clock-enable to the gate.
- o_ack  output  NB_CH  per-channel grant: the clock is running for this request.
- o_state  output  2  FSM state: 0=OFF, 1=ON, 2=HOLD.

Behaviour:
- Reset: one clock, asynchronous active-low reset (i_clk, i_rst_n). Assertion asynchronously clears all flops: o_clk_en=0, o_ack=0, o_state=OFF, hold counter=0, synchronisers=0. Deassertion is assumed synchronised upstream.
- Synchroniser: req_s = i_req passed through SYNC_STAGES flops per bit. With SYNC_STAGES=0, req_s = i_req.
- Combined request: any_req = |(req_s & ~i_mask) | i_force_on. This is combinational and feeds only the FSM.
- OFF:
  - any_req=1 → ON, o_clk_en=1 from the next cycle.
  - Otherwise stay in OFF.
- ON:
  - any_req=0 and HOLD_CYCLES>0 → HOLD, counter loads HOLD_CYCLES-1.
  - any_req=0 and HOLD_CYCLES=0 → OFF, o_clk_en=0 next cycle.
  - Otherwise stay in ON.
- HOLD:
  - any_req=1 → ON, counter cleared. This takes priority over expiry.
  - Else counter==0 → OFF.
  - Else counter decrements.
- o_clk_en: 1 in ON and HOLD, 0 in OFF. It is a registered function of next-state, with no combinational path from inputs.
- Hold-off length: o_clk_en stays high exactly HOLD_CYCLES cycles after the first cycle any_req is seen low.
- o_ack[i]: registered; o_ack[i] <= o_clk_en & req_s[i] & ~i_mask[i].
  - Rises one cycle after o_clk_en rises.
  - Falls one cycle after req_s[i] or i_mask[i] drops, even while the FSM is in HOLD.
  - Never set in OFF.
  - i_force_on never sets any o_ack bit.
- Latency, i_req rise to o_clk_en rise: SYNC_STAGES+1 cycles from state OFF. o_ack follows 1 cycle later.
- Masking an active channel is equivalent to that channel dropping its request.
- If all channels are masked and i_force_on=0, the FSM drains to OFF through HOLD.
- Simultaneous events:
  - A request arriving on the same cycle the counter hits 0 keeps the FSM in ON; o_clk_en never drops.
  - A request drop on one channel and a rise on another in the same cycle keeps the FSM in ON.
- Counter width is clog2(HOLD_CYCLES+1), minimum 1. No wrap: it only decrements in HOLD and saturates at 0.
- Reset mid-HOLD or mid-ON: o_clk_en drops immediately (asynchronous). Any pending hold-off is discarded.

Test Plan:
- Reset default params, all i_req=0: o_clk_en=0, o_ack=0, o_state=0. Then raise i_req[2] at cycle 0 → o_clk_en=1 at cycle 3, o_ack[2]=1 at cycle 4, o_state=1.
- HOLD_CYCLES=8, drop i_req[2] at cycle 20:
  - o_ack[2]=0 at cycle 23.
  - o_state=2 from cycle 23.
  - o_clk_en stays 1 through cycle 30, falls at cycle 31.
  - Vary HOLD_CYCLES=0: o_clk_en falls at cycle 23.
- Re-request during HOLD: drop i_req[0], then raise i_req[1] 4 cycles later → o_state returns 1, o_clk_en never deasserts, o_ack[1]=1 after SYNC_STAGES+2 cycles. Also raise a request on exactly the counter==0 cycle → no o_clk_en gap.
- Masking: i_mask=4'b0100, i_req=4'b0100 → o_clk_en stays 0. Clear mask with request held → o_clk_en=1 after 1 cycle (mask is not synchronised).
- i_force_on=1 with i_req=0 → o_clk_en=1 next cycle, o_ack=0. Release → HOLD for HOLD_CYCLES cycles, then OFF.
- Assert i_rst_n=0 asynchronously mid-ON with NB_CH=8, SYNC_STAGES=0, requests active → o_clk_en and o_ack clear with no clock edge. After release with requests still high → o_clk_en=1 after 1 cycle.
